// File: rtl/fb_lock_selector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_lock_selector_pkg
// Description : Shared types and constants for the feedback lock selector:
//               the selector state encoding, the fault counter width and a
//               helper that sizes counters from their largest value.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_lock_selector_pkg;

  // Selector states: open-loop generator, locked to feedback, output blanking
  typedef enum logic [1:0] {
    GEN  = 2'd0,
    FB   = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int FAULT_CNT_W = 8;

  // Bits needed to hold 0..max_val without wrapping (never less than one bit)
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_lock_selector_edge_det_n.sv
`default_nettype none
// ============================================================================
// Module      : edge_det_n
// Description : Falling-edge detector for an input that is already
//               synchronous to clk. One register holds the previous sample;
//               the fall output is combinational from the current sample, so
//               the only latency is that single register.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_det_n (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic fall
);

  logic prev_d;
  logic prev_q;

  // Next value of the previous-sample register is simply the current input
  always_comb begin
    prev_d = din;
  end

  // Previous-sample register, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign fall = prev_q & ~din;

endmodule
`default_nettype wire

// File: rtl/fb_lock_selector.sv
`default_nettype none
// ============================================================================
// Module      : fb_lock_selector
// Description : Chooses between an open-loop generator drive (gen) and the
//               current-transformer feedback (fb). After enough generator
//               periods the output hands over to fb; loss of fb (timeout) or
//               repeated out-of-range fb periods (fault) drops back through a
//               blanking interval to the generator.
//               Build option: define SELECTOR_FAULT_CNT_EN to include the
//               saturating fault counter on fault_cnt; otherwise fault_cnt
//               is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_lock_selector
  import fb_lock_selector_pkg::*;
#(
  parameter int CLK_MHZ           = 100,
  parameter int PERIODS_TO_SWITCH = 4,
  parameter int RESET_TIMEOUT_US  = 4,
  parameter int FB_PER_MIN        = 50,
  parameter int FB_PER_MAX        = 2000,
  parameter int BAD_PER_MAX       = 2,
  parameter int HOLDOFF_CYCLES    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   gen,
  input  logic                   fb,
  output logic                   out,
  output logic                   locked,
  output logic                   fault,
  output logic [FAULT_CNT_W-1:0] fault_cnt
);

  localparam int TIMEOUT_LIMIT = CLK_MHZ * RESET_TIMEOUT_US;

  localparam int TO_W = cnt_w(TIMEOUT_LIMIT - 1);
  localparam int PC_W = cnt_w(PERIODS_TO_SWITCH);
  localparam int PM_W = cnt_w(FB_PER_MAX + 1);
  localparam int BC_W = cnt_w(BAD_PER_MAX);
  localparam int HC_W = cnt_w(HOLDOFF_CYCLES - 1);

  localparam logic [TO_W-1:0] TO_RELOAD  = TO_W'(TIMEOUT_LIMIT - 1);
  localparam logic [PC_W-1:0] PER_SWITCH = PC_W'(PERIODS_TO_SWITCH);
  localparam logic [PM_W-1:0] PM_SAT     = PM_W'(FB_PER_MAX + 1);
  // Measured period is per_meas+1, so the valid window is compared directly
  // against per_meas shifted down by one.
  localparam logic [PM_W-1:0] PM_LO      = PM_W'(FB_PER_MIN - 1);
  localparam logic [PM_W-1:0] PM_HI      = PM_W'(FB_PER_MAX - 1);
  localparam logic [BC_W-1:0] BAD_LIM    = BC_W'(BAD_PER_MAX);
  localparam logic [HC_W-1:0] HOLD_LAST  = HC_W'(HOLDOFF_CYCLES - 1);

  logic gen_fall;
  logic fb_fall;

  state_e            state_d,       state_q;
  logic [PC_W-1:0]   per_cnt_d,     per_cnt_q;
  logic [TO_W-1:0]   timeout_cnt_d, timeout_cnt_q;
  logic [PM_W-1:0]   per_meas_d,    per_meas_q;
  logic [BC_W-1:0]   bad_cnt_d,     bad_cnt_q;
  logic [HC_W-1:0]   hold_cnt_d,    hold_cnt_q;
  logic              fault_d,       fault_q;

  logic              period_bad;
  logic              drop_timeout;
  logic              drop_fault;
  logic [BC_W-1:0]   bad_next;

  edge_det_n u_gen_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (gen),
    .fall  (gen_fall)
  );

  edge_det_n u_fb_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (fb),
    .fall  (fb_fall)
  );

  // Next-state and counter update for the selector FSM
  always_comb begin
    state_d       = state_q;
    per_cnt_d     = per_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    per_meas_d    = per_meas_q;
    bad_cnt_d     = bad_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    fault_d       = 1'b0;
    period_bad    = (per_meas_q < PM_LO) || (per_meas_q > PM_HI);
    bad_next      = bad_cnt_q + 1'b1;
    drop_timeout  = 1'b0;
    drop_fault    = 1'b0;

    case (state_q)
      GEN: begin
        // Feedback counters sit at their entry values until fb takes over
        timeout_cnt_d = TO_RELOAD;
        per_meas_d    = '0;
        bad_cnt_d     = '0;
        if (gen_fall && (per_cnt_q != PER_SWITCH)) begin
          per_cnt_d = per_cnt_q + 1'b1;
        end
        if (fb_fall && (per_cnt_q == PER_SWITCH)) begin
          state_d = FB;
        end
      end

      FB: begin
        // fb high proves feedback is alive; low time runs the timeout down
        if (fb) begin
          timeout_cnt_d = TO_RELOAD;
        end else if (timeout_cnt_q != '0) begin
          timeout_cnt_d = timeout_cnt_q - 1'b1;
        end

        if (fb_fall) begin
          per_meas_d = '0;
        end else if (per_meas_q != PM_SAT) begin
          per_meas_d = per_meas_q + 1'b1;
        end

        if (fb_fall) begin
          if (period_bad) begin
            if (bad_next == BAD_LIM) begin
              drop_fault = 1'b1;
            end else begin
              bad_cnt_d = bad_next;
            end
          end else begin
            bad_cnt_d = '0;
          end
        end

        drop_timeout = (timeout_cnt_q == '0) && !gen;

        // Either cause enters HOLD once; only a period fault raises the pulse
        if (drop_timeout || drop_fault) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
          bad_cnt_d  = '0;
        end
        fault_d = drop_fault;
      end

      HOLD: begin
        timeout_cnt_d = TO_RELOAD;
        per_meas_d    = '0;
        bad_cnt_d     = '0;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = GEN;
          hold_cnt_d = '0;
          per_cnt_d  = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = GEN;
      end
    endcase
  end

  // Selector state and counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= GEN;
      per_cnt_q     <= '0;
      timeout_cnt_q <= TO_RELOAD;
      per_meas_q    <= '0;
      bad_cnt_q     <= '0;
      hold_cnt_q    <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      per_cnt_q     <= per_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      per_meas_q    <= per_meas_d;
      bad_cnt_q     <= bad_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      fault_q       <= fault_d;
    end
  end

  // Output mux: drive source follows the state, blanked during HOLD
  always_comb begin
    out = gen;
    case (state_q)
      FB:      out = fb;
      HOLD:    out = 1'b0;
      default: out = gen;
    endcase
  end

  assign locked = (state_q == FB);
  assign fault  = fault_q;

`ifdef SELECTOR_FAULT_CNT_EN
  logic [FAULT_CNT_W-1:0] fault_cnt_d;
  logic [FAULT_CNT_W-1:0] fault_cnt_q;

  // Count fault pulses, saturating; moves in step with the pulse itself
  always_comb begin
    fault_cnt_d = fault_cnt_q;
    if (fault_d && (fault_cnt_q != '1)) begin
      fault_cnt_d = fault_cnt_q + 1'b1;
    end
  end

  // Fault counter register, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_cnt_q <= '0;
    end else begin
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign fault_cnt = fault_cnt_q;
`else
  assign fault_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fb_lock_selector.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_lock_selector
// Description : Directed self-checking bench for fb_lock_selector with the
//               default parameters (100 MHz, 4 gen periods, 4 us timeout,
//               fb period window 50..2000, 2 bad periods, 16-cycle holdoff).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_lock_selector;

  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

`ifdef SELECTOR_FAULT_CNT_EN
  localparam int EXP_CNT1 = 1;
`else
  localparam int EXP_CNT1 = 0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       gen   = 1'b0;
  logic       fb    = 1'b0;
  logic       out;
  logic       locked;
  logic       fault;
  logic [7:0] fault_cnt;

  int n_cmp      = 0;
  int n_err      = 0;
  int fault_seen = 0;

  fb_lock_selector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gen       (gen),
    .fb        (fb),
    .out       (out),
    .locked    (locked),
    .fault     (fault),
    .fault_cnt (fault_cnt)
  );

  always #5 clk = ~clk;

  // Tally fault pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (fault === 1'b1) fault_seen++;
  end

  // Apply inputs, cross one rising edge, settle 1 ns past it
  task automatic cyc(input logic g, input logic f);
    gen = g;
    fb  = f;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(L, L);
    cyc(L, L);
    rst_n = 1'b1;
  endtask

  // n gen periods (5 high / 5 low), fb held low
  task automatic gen_periods(input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < 5; i++) cyc(H, L);
      for (int i = 0; i < 5; i++) cyc(L, L);
    end
  endtask

  // Reset, 4 gen periods, then fb 50 high and the entry falling edge
  task automatic do_lock();
    do_reset();
    gen_periods(4);
    for (int i = 0; i < 50; i++) cyc(L, H);
    cyc(L, L);
  endtask

  // Next fb falling edge exactly n cycles after the previous one (the last
  // cycle applied must have been that previous falling edge). Low time is
  // kept well under the 400-cycle timeout.
  task automatic fall_after(input int n);
    int lo;
    int hi;
    lo = (n > 200) ? 100 : (n / 2 - 1);
    hi = n - 1 - lo;
    for (int i = 0; i < lo; i++) cyc(L, L);
    for (int i = 0; i < hi; i++) cyc(L, H);
    cyc(L, L);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(H, L);
    n_cmp++; if (out !== 1'b1) begin n_err++; $display("FAIL reset_out_hi: got %b expected 1", out); end
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %b expected 0", locked); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b expected 0", fault); end
    n_cmp++; if (fault_cnt !== 8'd0) begin n_err++; $display("FAIL reset_fault_cnt: got %0d expected 0", fault_cnt); end
    cyc(L, H);
    n_cmp++; if (out !== 1'b0) begin n_err++; $display("FAIL reset_out_lo: got %b expected 0", out); end
    rst_n = 1'b1;
  endtask

  task automatic test_too_few_gen();
    do_reset();
    gen_periods(3);
    for (int i = 0; i < 50; i++) cyc(L, H);
    cyc(L, L);
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL few_gen_locked: got %b expected 0", locked); end
  endtask

  task automatic test_lock();
    int f0;
    do_reset();
    f0 = fault_seen;
    gen_periods(4);
    for (int i = 0; i < 50; i++) cyc(L, H);
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL lock_pre_edge: got %b expected 0", locked); end
    n_cmp++; if (out !== 1'b0) begin n_err++; $display("FAIL lock_out_gen: got %b expected 0", out); end
    cyc(L, L);
    n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL lock_entry: got %b expected 1", locked); end
    for (int i = 0; i < 49; i++) cyc(L, L);
    cyc(L, H);
    n_cmp++; if (out !== 1'b1) begin n_err++; $display("FAIL lock_out_fb: got %b expected 1", out); end
    for (int i = 0; i < 49; i++) cyc(L, H);
    cyc(L, L);
    fall_after(100);
    fall_after(100);
    n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL lock_hold_100: got %b expected 1", locked); end
    n_cmp++; if (fault_seen - f0 !== 0) begin n_err++; $display("FAIL lock_no_fault: got %0d pulses expected 0", fault_seen - f0); end
  endtask

  task automatic test_timeout();
    int f0;
    int blank_bad;
    do_lock();
    f0 = fault_seen;
    for (int i = 0; i < 399; i++) cyc(L, L);
    n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL to_before: got %b expected 1", locked); end
    cyc(L, L);
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL to_drop: got %b expected 0", locked); end
    blank_bad = 0;
    for (int i = 0; i < 15; i++) begin
      cyc(H, H);
      if (out !== 1'b0) blank_bad++;
    end
    n_cmp++; if (blank_bad !== 0) begin n_err++; $display("FAIL to_blank: got %0d nonzero cycles expected 0", blank_bad); end
    cyc(H, H);
    n_cmp++; if (out !== 1'b1) begin n_err++; $display("FAIL to_back_gen_out: got %b expected 1", out); end
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL to_back_gen_locked: got %b expected 0", locked); end
    cyc(L, L);
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL to_per_cnt_clear: got %b expected 0", locked); end
    n_cmp++; if (fault_seen - f0 !== 0) begin n_err++; $display("FAIL to_no_fault: got %0d pulses expected 0", fault_seen - f0); end
  endtask

  task automatic test_fault();
    int f0;
    do_lock();
    f0 = fault_seen;
    fall_after(30);
    n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL flt_first_bad: got %b expected 1", locked); end
    fall_after(30);
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL flt_drop: got %b expected 0", locked); end
    n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL flt_pulse: got %b expected 1", fault); end
    cyc(L, L);
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL flt_pulse_end: got %b expected 0", fault); end
    cyc(L, L);
    n_cmp++; if (fault_seen - f0 !== 1) begin n_err++; $display("FAIL flt_pulse_count: got %0d expected 1", fault_seen - f0); end
    n_cmp++; if (fault_cnt !== 8'(EXP_CNT1)) begin n_err++; $display("FAIL flt_cnt: got %0d expected %0d", fault_cnt, EXP_CNT1); end
  endtask

  task automatic test_recover();
    int f0;
    do_lock();
    f0 = fault_seen;
    fall_after(30);
    fall_after(100);
    fall_after(30);
    n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL rec_bad_cleared: got %b expected 1", locked); end
    fall_after(100);
    n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL rec_still_locked: got %b expected 1", locked); end
    n_cmp++; if (fault_seen - f0 !== 0) begin n_err++; $display("FAIL rec_no_fault: got %0d pulses expected 0", fault_seen - f0); end
  endtask

  task automatic test_boundary();
    do_lock();
    fall_after(50);
    fall_after(50);
    n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL bnd_min: got %b expected 1", locked); end
    fall_after(2000);
    fall_after(2000);
    n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL bnd_max: got %b expected 1", locked); end
    fall_after(49);
    n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL bnd_49_once: got %b expected 1", locked); end
    fall_after(2001);
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL bnd_2001_drop: got %b expected 0", locked); end
    n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL bnd_fault: got %b expected 1", fault); end
  endtask

  task automatic test_reset_mid();
    int f0;
    do_lock();
    fall_after(100);
    f0 = fault_seen;
    rst_n = 1'b0;
    cyc(L, H);
    rst_n = 1'b1;
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL rstmid_locked: got %b expected 0", locked); end
    n_cmp++; if (out !== 1'b0) begin n_err++; $display("FAIL rstmid_out: got %b expected 0", out); end
    cyc(L, H);
    cyc(L, L);
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL rstmid_per_cnt: got %b expected 0", locked); end
    // Reset landing on the edge that would have raised the fault
    do_lock();
    fall_after(30);
    for (int i = 0; i < 14; i++) cyc(L, L);
    for (int i = 0; i < 15; i++) cyc(L, H);
    rst_n = 1'b0;
    cyc(L, L);
    rst_n = 1'b1;
    cyc(L, L);
    cyc(L, L);
    n_cmp++; if (fault_seen - f0 !== 0) begin n_err++; $display("FAIL rstflt_no_pulse: got %0d pulses expected 0", fault_seen - f0); end
    n_cmp++; if (fault_cnt !== 8'd0) begin n_err++; $display("FAIL rstflt_cnt: got %0d expected 0", fault_cnt); end
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL rstflt_locked: got %b expected 0", locked); end
  endtask

  initial begin
    test_reset();
    test_too_few_gen();
    test_lock();
    test_timeout();
    test_fault();
    test_recover();
    test_boundary();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "time limit reached");
  end

endmodule
`default_nettype wire
